// File: rtl/rom_port_arbiter_pkg.sv
// rom_arb_pkg: shared types and helpers for the ROM port arbiter.
//   rom_port_e  - identifies which requester won the ROM this cycle
//   WORD_BYTES  - bytes per ROM word
//   addr_ok()   - legality check for a word read at a byte address
package rom_arb_pkg;

  typedef enum logic [0:0] {PORT_F, PORT_D} rom_port_e;

  localparam int WORD_BYTES = 4;

  // A word read is legal when it is word aligned and its last byte still
  // lies inside the ROM, so no read ever wraps past the top address.
  function automatic logic addr_ok(input logic [31:0] addr, input int addr_width);
    logic [32:0] last_word;
    last_word = (33'd1 << addr_width) - 33'(WORD_BYTES);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} <= last_word);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: bundles the fetch port, the data port and the ROM
// side of the arbiter.
//   master modport - requesters plus ROM model (drive req/addr, rom_rdata)
//   slave modport  - the arbiter (drives gnt, responses, rom_addr)
interface rom_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  import rom_arb_pkg::*;

  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;
  logic                  f_err;

  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_rdata;

  modport master (
    output f_req, f_addr, d_req, d_addr, rom_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  d_gnt, d_rvalid, d_rdata, d_err, rom_addr
  );

  modport slave (
    input  f_req, f_addr, d_req, d_addr, rom_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output d_gnt, d_rvalid, d_rdata, d_err, rom_addr
  );

endinterface

// File: rtl/rom_port_arbiter_resp_reg.sv
// rom_resp_reg: one-cycle response register for a single arbiter port.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load         - this port won the ROM in the current cycle
//   ok           - the winning address passed the legality check
//   rom_rdata    - combinational ROM word for the granted address
//   rvalid       - single-cycle response strobe
//   rdata, err   - response word and error; held while rvalid is low
module rom_resp_reg
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  ok,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  err_p1;

  // Stage p1: capture the granted access; an illegal access returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= load;
      if (load) begin
        data_p1 <= ok ? rom_rdata : '0;
        err_p1  <= !ok;
      end
    end
  end

  assign rvalid = vld_p1;
  assign rdata  = data_p1;
  assign err    = err_p1;

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational big-endian instruction ROM
// between the fetch port (F) and a data read port (D). One access per
// cycle; D normally wins a collision, but F is forced through once it has
// lost MAX_WAIT consecutive cycles. Responses arrive one cycle after grant.
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - F/D request/response ports and ROM address/data (slave side)
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rom_port_arbiter_if.slave    bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0]            wait_cnt;
  logic                  f_win;
  logic                  d_win;
  rom_port_e             winner;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_ok;

  // Stage p0: arbitration, address check and ROM address drive.
  always_comb begin
    f_win    = bus.f_req && (!bus.d_req || (wait_cnt == WAIT_LIMIT));
    d_win    = bus.d_req && !f_win;
    winner   = f_win ? PORT_F : PORT_D;
    win_addr = (winner == PORT_F) ? bus.f_addr : bus.d_addr;
    win_ok   = addr_ok(32'(win_addr), ADDR_WIDTH);
  end

  assign bus.f_gnt    = f_win;
  assign bus.d_gnt    = d_win;
  // Illegal addresses are never presented to the ROM.
  assign bus.rom_addr = ((f_win || d_win) && win_ok) ? win_addr : '0;

  // Counts consecutive cycles a pending fetch lost to D; saturates at the
  // limit so the next collision goes to F.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (f_win || !bus.f_req) begin
      wait_cnt <= '0;
    end else if (d_win && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Stage p1: per-port response registers.
  rom_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_f_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (f_win),
    .ok        (win_ok),
    .rom_rdata (bus.rom_rdata),
    .rvalid    (bus.f_rvalid),
    .rdata     (bus.f_rdata),
    .err       (bus.f_err)
  );

  rom_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_d_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (d_win),
    .ok        (win_ok),
    .rom_rdata (bus.rom_rdata),
    .rvalid    (bus.d_rvalid),
    .rdata     (bus.d_rdata),
    .err       (bus.d_err)
  );

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational, byte-addressed, big-endian instruction ROM between two requesters: the fetch stage (port F) and a data-side read port (port D: constant loads, debug reads).
- Arbitrates one access per cycle, registers the returned word, and flags misaligned or out-of-range addresses.
- Bounds fetch starvation with a wait counter.
- Sits between the IF stage / MEM-stage load path and the ROM instance.

Parameters:
- ADDR_WIDTH, 10, ROM byte-address width; ROM holds 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 32, word width returned by the ROM; must be 32.
- MAX_WAIT, 3, consecutive cycles fetch may lose before it is forced to win; range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request
- f_addr  in  ADDR_WIDTH  fetch byte address
- f_gnt  out  1  fetch granted this cycle (combinational)
- f_rvalid  out  1  fetch response valid, one cycle
- f_rdata  out  DATA_WIDTH  fetch response word
- f_err  out  1  fetch response error, qualified by f_rvalid
- d_req  in  1  data request
- d_addr  in  ADDR_WIDTH  data byte address
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  data response valid, one cycle
- d_rdata  out  DATA_WIDTH  data response word
- d_err  out  1  data response error, qualified by d_rvalid
- rom_addr  out  ADDR_WIDTH  address to ROM
- rom_rdata  in  DATA_WIDTH  ROM read data, combinational from rom_addr

Behaviour:
- Reset (async on rst_n low): f_rvalid=0, d_rvalid=0, f_err=0, d_err=0, f_rdata=0, d_rdata=0, wait_cnt=0. Combinational outputs follow inputs: gnt=0 and rom_addr=0 when no request.
- Handshake: a requester holds req high with a stable address until its gnt is high in the same cycle. The grant cycle completes the transfer. A requester may drop req without a grant; this is legal and aborts the request.
- Arbitration per cycle:
  - Only one request → it wins.
  - Both request → D wins, unless wait_cnt == MAX_WAIT, in which case F wins.
  - Exactly one gnt is high if any req is high.
- wait_cnt:
  - Increments when f_req && d_gnt.
  - Clears when f_gnt or !f_req.
  - Saturates at MAX_WAIT; never exceeds it.
- Address check on the winner:
  - Error if addr[1:0] != 0, or addr > 2^ADDR_WIDTH-4 (the word would wrap past the end of the ROM).
  - No wrap-around read is ever issued.
- rom_addr: the winner's address when granted and valid; 0 otherwise (no grant, or error).
- Response latency is 1 cycle. At the posedge ending the grant cycle, the winner's rdata register loads rom_rdata (or 0 on error), its err loads the check result, and its rvalid pulses high for exactly one cycle.
- rdata holds its last value when rvalid is low; the loser's response registers are unchanged.
- Back-to-back grants to the same port give rvalid high on consecutive cycles.
- Grant to F in cycle N and to D in cycle N+1 gives f_rvalid in N+1 and d_rvalid in N+2.
- Reset mid-operation: a pending response is discarded (rvalid never asserts for it) and wait_cnt returns to 0.

Decomposition:
- Package rom_arb_pkg holds:
  - typedef enum logic [0:0] {PORT_F, PORT_D} rom_port_e
  - localparam WORD_BYTES = 4
  - function addr_ok(addr), parameterised by width via the ADDR_WIDTH argument
- One natural sub-module, rom_resp_reg: rdata/err/rvalid register per port, instantiated twice.

Test Plan:
- Reset then idle, f_req=d_req=0 for 5 cycles → all gnt=0, rvalid=0, rom_addr=0, rdata=0.
- f_req=1, f_addr=0x008, ROM word at 0x008 = 0x2408_0005 → f_gnt=1 same cycle; f_rvalid=1, f_rdata=0x2408_0005, f_err=0 next cycle only.
- f_req and d_req both held high, MAX_WAIT=3, distinct aligned addresses → grant sequence D,D,D,F,D,D,D,F; wait_cnt never exceeds 3; every response lands one cycle after its grant.
- d_req with d_addr=0x006 (misaligned) → d_gnt=1, rom_addr=0, next cycle d_rvalid=1, d_err=1, d_rdata=0.
- d_req with d_addr=0x3FC → valid last word, d_err=0. d_addr=0x3FD → d_err=1 (misaligned). Then d_addr=0x3FE → d_err=1; no wrap access, rom_addr=0.
- Grant F at 0x010, assert rst_n=0 mid-cycle before the posedge → f_rvalid stays 0 and f_rdata=0. After release, the first F request behaves normally with wait_cnt=0.
